// File: rtl/dmaw_sched_pkg.sv
// Shared types and helpers for the 4-channel write-DMA scheduler.
// Optional build macro: DMAW_SCHED_FIXED_PRIO_EN (fixed priority pick).
package dmaw_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int BEAT_W = 15;
  localparam int ID_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  // Number of 32-bit words touched by a byte run of len+1 starting at addr_lo.
  function automatic logic [BEAT_W-1:0] beat_cnt_calc(
    input logic [1:0]  addr_lo,
    input logic [15:0] len
  );
    logic [16:0] sum;
    sum = {15'd0, addr_lo} + {1'b0, len} + 17'd4;
    return sum[BEAT_W+1:2];
  endfunction

endpackage

// File: rtl/dmaw_rr_pick.sv
// Combinational 4-way channel picker: round robin from rr_ptr_i,
// or fixed priority (ch0 first) when DMAW_SCHED_FIXED_PRIO_EN is defined.
module dmaw_rr_pick
  import dmaw_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] elig_i,
  input  logic [ID_W-1:0]   rr_ptr_i,
  output logic [ID_W-1:0]   gnt_id_o,
  output logic              gnt_vld_o
);

  logic [ID_W-1:0] base;
  logic [ID_W-1:0] idx;

`ifdef DMAW_SCHED_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^rr_ptr_i;
  assign base      = '0;
`else
  assign base = rr_ptr_i;
`endif

  // Scan from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = base + ID_W'(i);
      if (elig_i[idx]) begin
        gnt_id_o  = idx;
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmaw_ch_sched.sv
// 4-channel write-DMA scheduler in front of the 1D dma_w_* converter port.
// Optional build macro: DMAW_SCHED_FIXED_PRIO_EN (fixed priority, ch0 first).
module dmaw_ch_sched
  import dmaw_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_CH-1:0]    cfg_ch_en,
  input  logic                 cfg_dma_halt,
  input  logic [NUM_CH-1:0]    ch_w_req,
  output logic [NUM_CH-1:0]    ch_w_ack,
  input  logic [NUM_CH*32-1:0] ch_w_addr,
  input  logic [NUM_CH*16-1:0] ch_w_len,
  input  logic [NUM_CH-1:0]    ch_w_dvld,
  input  logic [NUM_CH*32-1:0] ch_wdata,
  input  logic [NUM_CH*4-1:0]  ch_wbe,
  output logic [NUM_CH-1:0]    ch_w_dack,
  output logic                 dma_w_req,
  input  logic                 dma_w_ack,
  output logic [31:0]          dma_w_addr,
  output logic [15:0]          dma_w_len,
  output logic                 dma_w_dvld,
  output logic [31:0]          dma_wdata,
  output logic [3:0]           dma_wbe,
  input  logic                 dma_w_dack,
  output logic                 sched_busy,
  output logic [ID_W-1:0]      sched_ch
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;

  logic [NUM_CH-1:0] elig;
  logic [ID_W-1:0]   pick_id;
  logic              pick_vld;
  logic              beat;

  assign elig = ch_w_req & cfg_ch_en;

  dmaw_rr_pick u_pick (
    .elig_i    (elig),
    .rr_ptr_i  (rr_q),
    .gnt_id_o  (pick_id),
    .gnt_vld_o (pick_vld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    dma_w_req  = 1'b0;
    dma_w_addr = '0;
    dma_w_len  = '0;
    dma_w_dvld = 1'b0;
    dma_wdata  = '0;
    dma_wbe    = '0;
    ch_w_ack   = '0;
    ch_w_dack  = '0;
    beat       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld && !cfg_dma_halt) begin
          state_d = S_REQ;
          gnt_d   = pick_id;
          cnt_d   = beat_cnt_calc(
                      ch_w_addr[pick_id*32 +: 2],
                      ch_w_len[pick_id*16 +: 16]);
        end
      end
      S_REQ: begin
        dma_w_req       = 1'b1;
        dma_w_addr      = ch_w_addr[gnt_q*32 +: 32];
        dma_w_len       = ch_w_len[gnt_q*16 +: 16];
        ch_w_ack[gnt_q] = dma_w_ack;
        if (dma_w_ack) state_d = S_DATA;
      end
      S_DATA: begin
        dma_w_dvld       = ch_w_dvld[gnt_q];
        dma_wdata        = ch_wdata[gnt_q*32 +: 32];
        dma_wbe          = ch_wbe[gnt_q*4 +: 4];
        ch_w_dack[gnt_q] = dma_w_dack;
        beat             = dma_w_dvld & dma_w_dack;
        if (beat) begin
          cnt_d = cnt_q - 1'b1;
          // Last word of the transfer: release the port.
          if (cnt_q == BEAT_W'(1)) begin
            state_d = S_IDLE;
`ifndef DMAW_SCHED_FIXED_PRIO_EN
            rr_d    = gnt_q + 2'd1;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sched_busy = (state_q != S_IDLE);
  assign sched_ch   = gnt_q;

endmodule

// File: tb/tb_dmaw_ch_sched.sv
// Self-checking bench for dmaw_ch_sched: per-cycle reference model
// plus directed scenarios with hand-computed counts and grant orders.
module tb_dmaw_ch_sched;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   cfg_ch_en;
  logic         cfg_dma_halt;
  logic [3:0]   ch_w_req;
  logic [3:0]   ch_w_ack;
  logic [127:0] ch_w_addr;
  logic [63:0]  ch_w_len;
  logic [3:0]   ch_w_dvld;
  logic [127:0] ch_wdata;
  logic [15:0]  ch_wbe;
  logic [3:0]   ch_w_dack;
  logic         dma_w_req;
  logic         dma_w_ack;
  logic [31:0]  dma_w_addr;
  logic [15:0]  dma_w_len;
  logic         dma_w_dvld;
  logic [31:0]  dma_wdata;
  logic [3:0]   dma_wbe;
  logic         dma_w_dack;
  logic         sched_busy;
  logic [1:0]   sched_ch;

  dmaw_ch_sched dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_ch_en    (cfg_ch_en),
    .cfg_dma_halt (cfg_dma_halt),
    .ch_w_req     (ch_w_req),
    .ch_w_ack     (ch_w_ack),
    .ch_w_addr    (ch_w_addr),
    .ch_w_len     (ch_w_len),
    .ch_w_dvld    (ch_w_dvld),
    .ch_wdata     (ch_wdata),
    .ch_wbe       (ch_wbe),
    .ch_w_dack    (ch_w_dack),
    .dma_w_req    (dma_w_req),
    .dma_w_ack    (dma_w_ack),
    .dma_w_addr   (dma_w_addr),
    .dma_w_len    (dma_w_len),
    .dma_w_dvld   (dma_w_dvld),
    .dma_wdata    (dma_wdata),
    .dma_wbe      (dma_wbe),
    .dma_w_dack   (dma_w_dack),
    .sched_busy   (sched_busy),
    .sched_ch     (sched_ch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester / slave knobs, applied at posedge+1 by step().
  int          pend[4];
  logic [31:0] caddr[4];
  logic [15:0] clen[4];
  logic        rst_nx, halt_nx, stall;
  logic [3:0]  en_nx;
  int          ack_dly, reqcnt;

  // Samples taken at negedge.
  logic [3:0] s_ack;
  logic       s_req, s_busy, s_dvld;
  logic [1:0] s_ch;

  int beats[4];
  int gq[$];

  // Reference model, written from the scheduling rules.
  int m_phase;
  int m_ch;
  int m_left;
  int m_start;

  always @(negedge clk) begin
    logic [31:0] ea, ed;
    logic [15:0] el;
    logic        ereq, edv, ebusy;
    logic [3:0]  ebe, eack, edack, elig;
    logic [1:0]  ech;
    logic        found;
    ea = '0; ed = '0; el = '0; ereq = 0; edv = 0; ebusy = 0;
    ebe = '0; eack = '0; edack = '0; ech = '0; elig = '0; found = 0;
    if (!rstn) begin
      m_phase = 0; m_ch = 0; m_left = 0; m_start = 0;
    end else begin
      ebusy = (m_phase != 0);
      ech   = 2'(m_ch);
      if (m_phase == 1) begin
        ereq = 1'b1;
        ea   = ch_w_addr[m_ch*32 +: 32];
        el   = ch_w_len[m_ch*16 +: 16];
        eack = dma_w_ack ? (4'b0001 << m_ch) : 4'b0000;
      end
      if (m_phase == 2) begin
        edv   = ch_w_dvld[m_ch];
        ed    = ch_wdata[m_ch*32 +: 32];
        ebe   = ch_wbe[m_ch*4 +: 4];
        edack = dma_w_dack ? (4'b0001 << m_ch) : 4'b0000;
      end
    end
    chk("req",   64'(dma_w_req),  64'(ereq));
    chk("addr",  64'(dma_w_addr), 64'(ea));
    chk("len",   64'(dma_w_len),  64'(el));
    chk("dvld",  64'(dma_w_dvld), 64'(edv));
    chk("wdata", 64'(dma_wdata),  64'(ed));
    chk("wbe",   64'(dma_wbe),    64'(ebe));
    chk("ack",   64'(ch_w_ack),   64'(eack));
    chk("dack",  64'(ch_w_dack),  64'(edack));
    chk("busy",  64'(sched_busy), 64'(ebusy));
    chk("ch",    64'(sched_ch),   64'(ech));
    if (rstn) begin
      if (dma_w_dvld && dma_w_dack) beats[sched_ch]++;
      if (ch_w_ack != 0) gq.push_back(int'(sched_ch));
      case (m_phase)
        0: begin
          elig = ch_w_req & cfg_ch_en;
          if (elig != 0 && !cfg_dma_halt) begin
            for (int k = 0; k < 4; k++) begin
              int c;
              c = (m_start + k) % 4;
              if (!found && elig[c]) begin
                found = 1;
                m_ch  = c;
              end
            end
            m_left = (int'(ch_w_addr[m_ch*32 +: 2]) +
                      int'(ch_w_len[m_ch*16 +: 16]) + 4) / 4;
            m_phase = 1;
          end
        end
        1: if (dma_w_ack) m_phase = 2;
        2: if (ch_w_dvld[m_ch] && dma_w_dack) begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 0;
`ifndef DMAW_SCHED_FIXED_PRIO_EN
            m_start = (m_ch + 1) % 4;
`endif
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rstn         = rst_nx;
    cfg_ch_en    = en_nx;
    cfg_dma_halt = halt_nx;
    for (int c = 0; c < 4; c++) begin
      if (s_ack[c] && pend[c] > 0) pend[c]--;
      ch_w_req[c]           = (pend[c] > 0);
      ch_w_addr[c*32 +: 32] = caddr[c];
      ch_w_len[c*16 +: 16]  = clen[c];
    end
    if (!rst_nx) begin
      dma_w_ack = 0; reqcnt = 0;
    end else if (dma_w_ack && s_req) begin
      dma_w_ack = 0; reqcnt = 0;
    end else if (s_req) begin
      reqcnt++;
      if (reqcnt >= ack_dly) dma_w_ack = 1;
    end
    dma_w_dack = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    ch_wdata   = {$urandom, $urandom, $urandom, $urandom};
    ch_wbe     = 16'($urandom);
    @(negedge clk);
    s_ack  = ch_w_ack;
    s_req  = dma_w_req;
    s_busy = sched_busy;
    s_dvld = dma_w_dvld;
    s_ch   = sched_ch;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((pend[0] + pend[1] + pend[2] + pend[3] > 0 || s_busy)
           && n < budget) begin
      step();
      n++;
    end
    chk("run_idle_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic set_ch(input int c, input logic [31:0] a,
                        input logic [15:0] l);
    caddr[c] = a;
    clen[c]  = l;
  endtask

  int b0;
  int busy_cnt;
  int exp_ord[5];
  int exp_rr[3];

  initial begin
    rstn = 0; cfg_ch_en = 4'hF; cfg_dma_halt = 0; ch_w_req = '0;
    ch_w_addr = '0; ch_w_len = '0; ch_w_dvld = 4'hF;
    ch_wdata = '0; ch_wbe = '0; dma_w_ack = 0; dma_w_dack = 0;
    rst_nx = 0; halt_nx = 0; stall = 0; en_nx = 4'hF;
    ack_dly = 1; reqcnt = 0;
    s_ack = '0; s_req = 0; s_busy = 0; s_dvld = 0; s_ch = '0;
    for (int c = 0; c < 4; c++) begin
      pend[c] = 0; beats[c] = 0; caddr[c] = '0; clen[c] = '0;
    end

    // Reset state
    repeat (3) step();
    chk("rst_busy", 64'(sched_busy), 64'd0);
    chk("rst_req",  64'(dma_w_req),  64'd0);
    chk("rst_addr", 64'(dma_w_addr), 64'd0);
    chk("rst_ch",   64'(sched_ch),   64'd0);
    rst_nx = 1;
    repeat (2) step();

    // Contention: all four, 16 beats each, ch0 asks twice
    for (int c = 0; c < 4; c++) set_ch(c, 32'h2000_0000 + c*32'h100, 16'h003F);
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
`ifdef DMAW_SCHED_FIXED_PRIO_EN
    exp_ord = '{0, 0, 1, 2, 3};
`else
    exp_ord = '{0, 1, 2, 3, 0};
`endif
    run_idle(2000);
    chk("cont_n", 64'(gq.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < gq.size()) chk("cont_ord", 64'(gq[i]), 64'(exp_ord[i]));
    chk("cont_b0", 64'(beats[0]), 64'd32);
    chk("cont_b1", 64'(beats[1]), 64'd16);
    chk("cont_b3", 64'(beats[3]), 64'd16);

    // Single channel: ch1, addr ...03, len 1 -> 2 beats
    gq.delete();
    ack_dly = 2;
    set_ch(1, 32'h1000_0003, 16'h0001);
    b0 = beats[1];
    pend[1] = 1;
    run_idle(200);
    chk("single_beats", 64'(beats[1] - b0), 64'd2);
    chk("single_n", 64'(gq.size()), 64'd1);
    if (gq.size() > 0) chk("single_ch", 64'(gq[0]), 64'd1);

    // Pointer now 2 (rr): ch0,2,3 one-beat transfers
    gq.delete();
    ack_dly = 1;
    for (int c = 0; c < 4; c++) set_ch(c, 32'h3000_0000, 16'h0003);
    pend[0] = 1; pend[2] = 1; pend[3] = 1;
`ifdef DMAW_SCHED_FIXED_PRIO_EN
    exp_rr = '{0, 2, 3};
`else
    exp_rr = '{2, 3, 0};
`endif
    run_idle(200);
    chk("rr_n", 64'(gq.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < gq.size()) chk("rr_ord", 64'(gq[i]), 64'(exp_rr[i]));

    // Halt during ch2 data
    gq.delete();
    set_ch(2, 32'h4000_0000, 16'h003F);
    set_ch(0, 32'h4100_0000, 16'h0003);
    b0 = beats[2];
    pend[2] = 1;
    for (int n = 0; n < 50 && !s_dvld; n++) step();
    chk("halt_in_data", 64'(s_dvld), 64'd1);
    halt_nx = 1;
    pend[0] = 1;
    for (int n = 0; n < 100 && s_busy; n++) step();
    chk("halt_beats", 64'(beats[2] - b0), 64'd16);
    busy_cnt = 0;
    repeat (6) begin
      step();
      if (s_busy) busy_cnt++;
    end
    chk("halt_nogrant", 64'(busy_cnt), 64'd0);
    halt_nx = 0;
    step();
    chk("halt_rel_idle", 64'(s_busy), 64'd0);
    step();
    chk("resume_busy", 64'(s_busy), 64'd1);
    chk("resume_ch", 64'(s_ch), 64'd0);
    run_idle(200);

    // Enable mask 1101: ch1 and ch3 ask, only ch3 served
    gq.delete();
    set_ch(1, 32'h5000_0000, 16'h0007);
    set_ch(3, 32'h5100_0000, 16'h0007);
    en_nx = 4'b1101;
    pend[1] = 1; pend[3] = 1;
    for (int n = 0; n < 100 && (pend[3] > 0 || s_busy); n++) step();
    repeat (5) step();
    chk("mask_n", 64'(gq.size()), 64'd1);
    if (gq.size() > 0) chk("mask_ch", 64'(gq[0]), 64'd3);
    chk("mask_ch1_pend", 64'(pend[1]), 64'd1);
    en_nx = 4'hF;
    run_idle(200);

    // Max length: addr[1:0]=3, len FFFF -> 16385 beats
    set_ch(0, 32'h6000_0003, 16'hFFFF);
    b0 = beats[0];
    pend[0] = 1;
    run_idle(20000);
    chk("max_beats", 64'(beats[0] - b0), 64'd16385);

    // Backpressure, then reset mid-transfer
    stall = 1;
    set_ch(1, 32'h7000_0000, 16'h003F);
    b0 = beats[1];
    pend[1] = 1;
    run_idle(1000);
    chk("stall_beats", 64'(beats[1] - b0), 64'd16);
    set_ch(2, 32'h7100_0000, 16'h003F);
    b0 = beats[2];
    pend[2] = 1;
    for (int n = 0; n < 200 && (beats[2] - b0) < 5; n++) step();
    chk("mid_in_data", 64'(s_dvld | s_busy), 64'd1);
    pend[2] = 0;
    rst_nx = 0;
    step();
    chk("mrst_busy", 64'(sched_busy), 64'd0);
    chk("mrst_dvld", 64'(dma_w_dvld), 64'd0);
    chk("mrst_dack", 64'(ch_w_dack),  64'd0);
    chk("mrst_ack",  64'(ch_w_ack),   64'd0);
    chk("mrst_ch",   64'(sched_ch),   64'd0);
    rst_nx = 1;
    stall = 0;
    repeat (4) step();
    chk("post_busy", 64'(s_busy), 64'd0);
    chk("partial", 64'((beats[2] - b0) < 16), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
